// File: rtl/fd_inst_queue_if.sv
// Fetch/decode handshake bundle around the instruction queue.
// The slave modport is the queue itself; the master modport is the fetch/decode side.
interface fd_inst_queue_if #(
    parameter int N_BITS = 32,
    parameter int DEPTH  = 4
);
    logic                       f_valid;
    logic [N_BITS-1:0]          f_pc;
    logic [N_BITS-1:0]          f_pc_plus4;
    logic [N_BITS-1:0]          f_instr;
    logic                       stall;
    logic                       f_ready;
    logic                       flush;
    logic                       d_valid;
    logic [N_BITS-1:0]          d_pc;
    logic [N_BITS-1:0]          d_pc_plus4;
    logic [N_BITS-1:0]          d_instr;
    logic                       d_ready;
    logic [$clog2(DEPTH):0]     occupancy;

    modport slave (
        input  f_valid, f_pc, f_pc_plus4, f_instr, flush, d_ready,
        output stall, f_ready, d_valid, d_pc, d_pc_plus4, d_instr, occupancy
    );

    modport master (
        output f_valid, f_pc, f_pc_plus4, f_instr, flush, d_ready,
        input  stall, f_ready, d_valid, d_pc, d_pc_plus4, d_instr, occupancy
    );
endinterface

// File: rtl/fd_inst_queue.sv
// Fetch-to-decode instruction buffer: circular FIFO of {pc, pc_plus4, instr}
// with valid/ready toward decode, stall toward fetch and a flush on redirect.
module fd_inst_queue #(
    parameter int                N_BITS    = 32,
    parameter int                DEPTH     = 4,
    parameter logic [N_BITS-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic             clk,
    input  logic             rst_n,
    fd_inst_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [3*N_BITS-1:0]   mem [DEPTH];
    logic [3*N_BITS-1:0]   head;
    logic                  full;
    logic                  empty;
    logic                  enq;
    logic                  deq;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // f_ready comes only from registered count, so no d_ready -> stall path exists
    assign bus.f_ready   = !full;
    assign bus.stall     = full;
    assign bus.d_valid   = !empty && !bus.flush;
    assign bus.occupancy = count;

    assign enq = bus.f_valid && !full && !bus.flush;
    assign deq = bus.d_valid && bus.d_ready;

    assign head = mem[rd_ptr];

    always_comb begin
        bus.d_pc       = '0;
        bus.d_pc_plus4 = '0;
        bus.d_instr    = NOP_INSTR;
        if (bus.d_valid) begin
            bus.d_pc       = head[3*N_BITS-1:2*N_BITS];
            bus.d_pc_plus4 = head[2*N_BITS-1:N_BITS];
            bus.d_instr    = head[N_BITS-1:0];
        end
    end

    // storage carries no reset; valid entries are tracked by count alone
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= {bus.f_pc, bus.f_pc_plus4, bus.f_instr};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (enq && !deq) begin
                count <= count + CW'(1);
            end else if (deq && !enq) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fd_inst_queue.sv
// Self-checking bench for fd_inst_queue: directed vector table, streaming
// sequence and randomized traffic against a queue-based reference model.
module tb_fd_inst_queue;
    localparam int          N_BITS = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] IMASK  = 32'h5A5A0000;

    logic clk;
    logic rst_n;

    fd_inst_queue_if #(.N_BITS(N_BITS), .DEPTH(DEPTH)) bus ();

    fd_inst_queue #(.N_BITS(N_BITS), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        bit          rst;
        bit          fv;
        logic [31:0] pc;
        bit          fl;
        bit          dr;
        bit          ev;
        logic [31:0] epc;
        int          eocc;
        bit          est;
    } vec_t;

    ent_t mq[$];
    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void chk(string name, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic vec_t v(bit rst, bit fv, logic [31:0] pc, bit fl, bit dr,
                               bit ev, logic [31:0] epc, int eocc, bit est);
        vec_t r;
        r.rst = rst; r.fv = fv; r.pc = pc; r.fl = fl; r.dr = dr;
        r.ev = ev; r.epc = epc; r.eocc = eocc; r.est = est;
        return r;
    endfunction

    // drive inputs away from the clock edge, then compare against the model
    task automatic apply(bit rst, bit fv, logic [31:0] pc, bit fl, bit dr);
        bit          mv;
        logic [31:0] mpc, mpc4, minstr;
        @(negedge clk);
        rst_n          = rst;
        bus.f_valid    = fv;
        bus.f_pc       = pc;
        bus.f_pc_plus4 = pc + 32'd4;
        bus.f_instr    = pc ^ IMASK;
        bus.flush      = fl;
        bus.d_ready    = dr;
        #1;
        mv     = (mq.size() > 0) && !fl;
        mpc    = mv ? mq[0].pc    : 32'h0;
        mpc4   = mv ? mq[0].pc4   : 32'h0;
        minstr = mv ? mq[0].instr : NOP;
        chk("m_d_valid",   96'(bus.d_valid),    96'(mv));
        chk("m_d_pc",      96'(bus.d_pc),       96'(mpc));
        chk("m_d_pc4",     96'(bus.d_pc_plus4), 96'(mpc4));
        chk("m_d_instr",   96'(bus.d_instr),    96'(minstr));
        chk("m_f_ready",   96'(bus.f_ready),    96'(mq.size() != DEPTH));
        chk("m_stall",     96'(bus.stall),      96'(mq.size() == DEPTH));
        chk("m_occupancy", 96'(bus.occupancy),  96'(mq.size()));
    endtask

    task automatic tick();
        ent_t e;
        bit   ready;
        bit   do_deq;
        @(posedge clk);
        if (!rst_n || bus.flush) begin
            mq.delete();
        end else begin
            ready  = (mq.size() != DEPTH);
            do_deq = (mq.size() > 0) && bus.d_ready;
            if (do_deq) void'(mq.pop_front());
            if (bus.f_valid && ready) begin
                e.pc    = bus.f_pc;
                e.pc4   = bus.f_pc_plus4;
                e.instr = bus.f_instr;
                mq.push_back(e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.f_valid = 1'b0; bus.f_pc = '0; bus.f_pc_plus4 = '0; bus.f_instr = '0;
        bus.flush = 1'b0; bus.d_ready = 1'b0;
        repeat (2) @(posedge clk);
        mq.delete();

        // fill to full, attempt overflow
        tbl.push_back(v(1, 1, 32'h00, 0, 0, 0, 32'h00, 0, 0));
        tbl.push_back(v(1, 1, 32'h04, 0, 0, 1, 32'h00, 1, 0));
        tbl.push_back(v(1, 1, 32'h08, 0, 0, 1, 32'h00, 2, 0));
        tbl.push_back(v(1, 1, 32'h0C, 0, 0, 1, 32'h00, 3, 0));
        tbl.push_back(v(1, 1, 32'h10, 0, 0, 1, 32'h00, 4, 1));
        // drain in order
        tbl.push_back(v(1, 0, 32'h00, 0, 1, 1, 32'h00, 4, 1));
        tbl.push_back(v(1, 0, 32'h00, 0, 1, 1, 32'h04, 3, 0));
        tbl.push_back(v(1, 0, 32'h00, 0, 1, 1, 32'h08, 2, 0));
        tbl.push_back(v(1, 0, 32'h00, 0, 1, 1, 32'h0C, 1, 0));
        tbl.push_back(v(1, 0, 32'h00, 0, 0, 0, 32'h00, 0, 0));
        // three entries, then flush with a competing fetch
        tbl.push_back(v(1, 1, 32'h20, 0, 0, 0, 32'h00, 0, 0));
        tbl.push_back(v(1, 1, 32'h24, 0, 0, 1, 32'h20, 1, 0));
        tbl.push_back(v(1, 1, 32'h28, 0, 0, 1, 32'h20, 2, 0));
        tbl.push_back(v(1, 1, 32'h200, 1, 0, 0, 32'h00, 3, 0));
        tbl.push_back(v(1, 1, 32'h400, 0, 0, 0, 32'h00, 0, 0));
        tbl.push_back(v(1, 0, 32'h00, 0, 0, 1, 32'h400, 1, 0));
        // fill, then dequeue while full with a fetch that must retry
        tbl.push_back(v(1, 1, 32'h30, 0, 0, 1, 32'h400, 1, 0));
        tbl.push_back(v(1, 1, 32'h34, 0, 0, 1, 32'h400, 2, 0));
        tbl.push_back(v(1, 1, 32'h38, 0, 0, 1, 32'h400, 3, 0));
        tbl.push_back(v(1, 1, 32'h3C, 0, 1, 1, 32'h400, 4, 1));
        tbl.push_back(v(1, 1, 32'h3C, 0, 0, 1, 32'h30, 3, 0));
        tbl.push_back(v(1, 0, 32'h00, 0, 0, 1, 32'h30, 4, 1));
        // drain to two, then reset alongside enq/deq
        tbl.push_back(v(1, 0, 32'h00, 0, 1, 1, 32'h30, 4, 1));
        tbl.push_back(v(1, 0, 32'h00, 0, 1, 1, 32'h34, 3, 0));
        tbl.push_back(v(0, 1, 32'h50, 0, 1, 1, 32'h38, 2, 0));
        tbl.push_back(v(1, 0, 32'h00, 0, 0, 0, 32'h00, 0, 0));

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].fv, tbl[i].pc, tbl[i].fl, tbl[i].dr);
            chk($sformatf("v%0d_d_valid", i),   96'(bus.d_valid),   96'(tbl[i].ev));
            chk($sformatf("v%0d_d_pc", i),      96'(bus.d_pc),      96'(tbl[i].epc));
            chk($sformatf("v%0d_d_instr", i),   96'(bus.d_instr),
                96'(tbl[i].ev ? (tbl[i].epc ^ IMASK) : NOP));
            chk($sformatf("v%0d_occupancy", i), 96'(bus.occupancy), 96'(tbl[i].eocc));
            chk($sformatf("v%0d_stall", i),     96'(bus.stall),     96'(tbl[i].est));
            tick();
        end

        // streaming through three pointer wraps at one entry per cycle
        for (int i = 0; i < 12; i++) begin
            apply(1, 1, 32'h100 + 32'(4 * i), 0, 1);
            if (i == 0) begin
                chk("stream_first_empty", 96'(bus.d_valid), 96'(0));
            end else begin
                chk($sformatf("stream%0d_pc", i),  96'(bus.d_pc), 96'(32'h100 + 32'(4 * (i - 1))));
                chk($sformatf("stream%0d_occ", i), 96'(bus.occupancy), 96'(1));
            end
            tick();
        end
        apply(1, 0, 32'h0, 0, 1);
        chk("stream_tail_pc", 96'(bus.d_pc), 96'(32'h12C));
        tick();

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            apply(($urandom_range(0, 79) != 0),
                  ($urandom_range(0, 3) != 0),
                  $urandom(),
                  ($urandom_range(0, 24) == 0),
                  (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fd_inst_queue.md
Name: fd_inst_queue

Overview:
- Instruction buffer between the fetch stage and the decode stage.
- Captures each fetched {pc, pc_plus4, instr} triple in a small circular FIFO and presents the oldest entry to decode with a valid/ready handshake.
- Decouples decode stalls from the program-counter register.
- Back-pressures fetch through a stall output, and discards all buffered instructions on a control-flow redirect (flush).

Parameters:
- N_BITS, 32, width of pc, pc_plus4 and instruction fields.
- DEPTH, 4, number of entries; power of two, minimum 2.
- NOP_INSTR, 32'h00000013, instruction value driven on d_instr when the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- f_valid  input  1  fetch presents a valid instruction this cycle.
- f_pc  input  N_BITS  pc of fetched instruction.
- f_pc_plus4  input  N_BITS  pc+4 of fetched instruction.
- f_instr  input  N_BITS  fetched instruction word.
- stall  output  1  to fetch: queue cannot accept; equals !f_ready.
- f_ready  output  1  queue can accept an entry this cycle.
- flush  input  1  redirect (jal/branch/jalr taken); empties the queue.
- d_valid  output  1  d_pc/d_pc_plus4/d_instr hold a valid entry.
- d_pc  output  N_BITS  pc of head entry.
- d_pc_plus4  output  N_BITS  pc+4 of head entry.
- d_instr  output  N_BITS  instruction of head entry.
- d_ready  input  1  decode consumes the head entry this cycle.
- occupancy  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits.
  - count, $clog2(DEPTH)+1 bits.
  - Storage array of DEPTH x (3*N_BITS). Storage is not reset.
- Reset (rst_n=0 at a rising edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Resulting outputs: d_valid=0, d_instr=NOP_INSTR, d_pc=0, d_pc_plus4=0, f_ready=1, stall=0, occupancy=0.
  - Reset has priority over flush, enq and deq.
- f_ready:
  - f_ready = (count != DEPTH).
  - Depends on registered state only. There is no combinational path from d_ready to f_ready or stall.
- Enqueue (enq = f_valid && f_ready && !flush):
  - Writes the entry at wr_ptr.
  - wr_ptr increments modulo DEPTH.
- Dequeue (deq = d_valid && d_ready && !flush):
  - rd_ptr increments modulo DEPTH.
- count update:
  - enq and deq in the same cycle: count unchanged. This is legal at any occupancy where f_ready=1.
  - enq only: count+1.
  - deq only: count-1.
- Full (count == DEPTH):
  - f_ready=0 and stall=1.
  - An f_valid in this cycle is ignored; fetch must hold its pc.
  - A dequeue in the full cycle does not allow an enqueue in that same cycle. f_ready rises the following cycle.
- Empty (count == 0):
  - d_valid=0, d_instr=NOP_INSTR, d_pc=0, d_pc_plus4=0.
  - d_ready is ignored.
- Non-empty:
  - d_valid=1.
  - Data outputs are driven combinationally from storage[rd_ptr].
  - Outputs hold stable while d_ready=0.
- Latency: an entry enqueued at edge N is visible with d_valid=1 in the cycle after edge N. There is no bypass. Sustained throughput is 1 entry per cycle.
- Flush:
  - In the flush cycle, d_valid is forced to 0 and outputs show the empty values.
  - No enq or deq occurs in the flush cycle.
  - At the next edge, wr_ptr=0, rd_ptr=0, count=0.
  - The instruction fetched at the redirect target arrives with f_valid in the cycle after flush and is accepted (f_ready=1).
- Pointer wrap: pointers wrap from DEPTH-1 to 0. FIFO order is preserved across the wrap.
- occupancy equals count.

Test Plan:
1. Reset, then f_valid=1 with pc 0x0,0x4,0x8,0xC on consecutive cycles and d_ready=0.
   - count goes 1,2,3,4.
   - stall=1 after the 4th edge.
   - A 5th f_valid (pc 0x10) is not accepted.
   - d_pc stays 0x0 throughout.
2. From full, set d_ready=1 for 4 cycles with f_valid=0.
   - d_pc sequence is 0x0,0x4,0x8,0xC with d_valid=1.
   - Then d_valid=0 and d_instr=32'h00000013.
3. Streaming: f_valid=1 and d_ready=1 continuously for 12 cycles, pcs 0x100 onward.
   - Each pc appears on d_pc exactly one cycle after enqueue.
   - count stays 1.
   - Pointers wrap 3 times with no loss or duplication.
4. With 3 entries held, assert flush=1 together with f_valid=1 (pc 0x200).
   - In that cycle d_valid=0.
   - Next cycle count=0 and pc 0x200 is not stored.
   - f_valid with pc 0x400 the cycle after is accepted, and d_pc=0x400 one cycle later.
5. With 2 entries held, assert rst_n=0 for one edge simultaneously with f_valid=1 and d_ready=1.
   - After the edge: count=0, d_valid=0, stall=0, d_pc=0.
6. Full queue, d_ready=1 and f_valid=1 in the same cycle.
   - The head is dequeued and the new entry is rejected.
   - count=3 next cycle, f_ready=1.
   - The retried entry is accepted on the following edge.
